var_sum_unit: RTL and testbench

- Downstream consumer of the variable loader.
- Collects the four integral-image corner variables A, B, C and D for every processor core, delivered as block writes of WINDOW_BLOCKING elements.
- Once all four corners of all cores are present, streams one rectangle sum per core, sum = A - B - C + D, to the classifier stage.
- One window evaluation per start pulse.

---
 rtl/var_sum_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_var_sum_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/var_sum_unit.sv
// var_sum_unit: collects the integral-image corner values A, B, C, D for every
// core from block writes, then streams one rectangle sum (A - B - C + D) per
// core to the classifier stage.
// Optional build macro: VARSUM_DUP_CHECK_EN enables the sticky duplicate-write
// flag on err; without it err is tied low and no checking logic exists.
module var_sum_unit #(
    parameter int CORES           = 16,
    parameter int WINDOW_BLOCKING = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int OFFSET_BITS     = 2,
    parameter int CORE_BITS       = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [1:0]                           wr_var,
    input  logic [OFFSET_BITS-1:0]               wr_offset,
    input  logic [WINDOW_BLOCKING-1:0]           wr_mask,
    input  logic [WINDOW_BLOCKING*DATA_WIDTH-1:0] wr_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [CORE_BITS-1:0]                 out_core,
    output logic [DATA_WIDTH-1:0]                out_sum,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    // Four corner variables per core: 0=A, 1=B, 2=C, 3=D.
    localparam int NV = 4;
    // Drain counter runs one past the last core so "all loaded" is explicit.
    localparam logic [CORE_BITS:0]   CNT_END   = (CORE_BITS+1)'(CORES);
    localparam logic [CORE_BITS-1:0] LAST_CORE = CORE_BITS'(CORES - 1);

    typedef enum logic [1:0] {
        S_Idle,
        S_Collect,
        S_Drain,
        S_Done
    } state_t;

    state_t                  state_q, state_d;
    logic [CORES*NV-1:0]     flags_q, flags_d;
    logic [CORE_BITS:0]      cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [CORE_BITS-1:0]    out_core_q, out_core_d;
    logic [DATA_WIDTH-1:0]   out_sum_q, out_sum_d;
    logic                    pend_q, pend_d;

    logic                    wr_accept;
    logic                    start_clear;
    logic [CORES*NV-1:0]     set_vec;
    logic [NV*DATA_WIDTH-1:0] core_vars [CORES];
    logic [NV*DATA_WIDTH-1:0] sel_vars;
    logic [DATA_WIDTH-1:0]   sel_a, sel_b, sel_c, sel_d;

    // A start always wins over a write presented in the same cycle.
    assign wr_accept   = (state_q == S_Collect) && wr_valid && !start;
    // Cycles in which collection (re)starts and the loaded flags are wiped.
    assign start_clear = ((state_q == S_Idle) && (start || pend_q)) ||
                         (((state_q == S_Collect) || (state_q == S_Drain)) && start);

    // Per-core slot storage. Core gi can only be hit by block offset
    // gi / WINDOW_BLOCKING through lane gi % WINDOW_BLOCKING, so the write
    // decode is static per core; lanes mapping past the last core never match.
    generate
        for (genvar gi = 0; gi < CORES; gi++) begin : g_core
            localparam int EL  = gi % WINDOW_BLOCKING;
            localparam int OFS = gi / WINDOW_BLOCKING;

            logic [NV-1:0]         we;
            logic [DATA_WIDTH-1:0] slot_q [NV];

            // Decode which variable slot of this core the current write targets.
            always_comb begin
                we = '0;
                if (wr_accept && (int'(wr_offset) == OFS) && wr_mask[EL]) begin
                    we[wr_var] = 1'b1;
                end
            end

            // Variable storage carries no reset; the flags qualify its contents.
            always_ff @(posedge clk) begin
                for (int v = 0; v < NV; v++) begin
                    if (we[v]) begin
                        slot_q[v] <= wr_data[EL*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            assign set_vec[gi*NV +: NV] = we;
            assign core_vars[gi] = {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
        end
    endgenerate

    // Pick the corner values of the core currently being drained.
    always_comb begin
        sel_vars = core_vars[cnt_q[CORE_BITS-1:0]];
        sel_a    = sel_vars[0*DATA_WIDTH +: DATA_WIDTH];
        sel_b    = sel_vars[1*DATA_WIDTH +: DATA_WIDTH];
        sel_c    = sel_vars[2*DATA_WIDTH +: DATA_WIDTH];
        sel_d    = sel_vars[3*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state, flag, drain counter and output register update.
    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_core_d  = out_core_q;
        out_sum_d   = out_sum_q;
        pend_d      = pend_q;

        case (state_q)
            S_Idle: begin
                if (start || pend_q) begin
                    state_d = S_Collect;
                    flags_d = '0;
                    pend_d  = 1'b0;
                end
            end

            S_Collect: begin
                if (start) begin
                    flags_d = '0;
                end else begin
                    flags_d = flags_q | set_vec;
                    if (&flags_d) begin
                        state_d = S_Drain;
                        cnt_d   = '0;
                    end
                end
            end

            S_Drain: begin
                if (start) begin
                    out_valid_d = 1'b0;
                    flags_d     = '0;
                    state_d     = S_Collect;
                end else begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        if (out_core_q == LAST_CORE) begin
                            state_d = S_Done;
                        end
                    end
                    if ((!out_valid_q || out_ready) && (cnt_q < CNT_END)) begin
                        out_valid_d = 1'b1;
                        out_core_d  = cnt_q[CORE_BITS-1:0];
                        out_sum_d   = sel_d - sel_b - sel_c + sel_a;
                        cnt_d       = cnt_q + 1'b1;
                    end
                end
            end

            S_Done: begin
                // A start seen here is remembered and acted on from S_Idle.
                state_d = S_Idle;
                if (start) begin
                    pend_d = 1'b1;
                end
            end

            default: begin
                state_d = S_Idle;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_Idle;
            flags_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_core_q  <= '0;
            out_sum_q   <= '0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_core_q  <= out_core_d;
            out_sum_q   <= out_sum_d;
            pend_q      <= pend_d;
        end
    end

`ifdef VARSUM_DUP_CHECK_EN
    logic err_q, err_d;

    // Sticky flag: any accepted element landing on an already loaded slot.
    always_comb begin
        err_d = err_q;
        if (start_clear) begin
            err_d = 1'b0;
        end else if (wr_accept && (|(set_vec & flags_q))) begin
            err_d = 1'b1;
        end
    end

    // Duplicate flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_clear;
    assign unused_clear = start_clear;
    assign err = 1'b0;
`endif

    assign wr_ready  = (state_q == S_Collect);
    assign busy      = (state_q == S_Collect) || (state_q == S_Drain);
    assign done      = (state_q == S_Done);
    assign out_valid = out_valid_q;
    assign out_core  = out_core_q;
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_var_sum_unit.sv
// Randomized self-checking bench for var_sum_unit with a per-core reference
// store of A/B/C/D updated from the block-write rules.
module tb_var_sum_unit;
    localparam int CORES = 16;
    localparam int WB    = 4;
    localparam int DW    = 32;
    localparam int OB    = 2;
    localparam int CB    = 4;
`ifdef VARSUM_DUP_CHECK_EN
    localparam logic DUP_EN = 1'b1;
`else
    localparam logic DUP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [1:0]        wr_var = '0;
    logic [OB-1:0]     wr_offset = '0;
    logic [WB-1:0]     wr_mask = '0;
    logic [WB*DW-1:0]  wr_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CB-1:0]     out_core;
    logic [DW-1:0]     out_sum;
    logic              busy;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] ref_mem [CORES][4];

    var_sum_unit #(
        .CORES(CORES), .WINDOW_BLOCKING(WB), .DATA_WIDTH(DW),
        .OFFSET_BITS(OB), .CORE_BITS(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_var(wr_var),
        .wr_offset(wr_offset), .wr_mask(wr_mask), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_core(out_core),
        .out_sum(out_sum), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_sum(input int c);
        return ref_mem[c][0] - ref_mem[c][1] - ref_mem[c][2] + ref_mem[c][3];
    endfunction

    function automatic logic [WB*DW-1:0] rnd_blk();
        logic [WB*DW-1:0] r;
        for (int i = 0; i < WB; i++) r[i*DW +: DW] = $urandom();
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block write; the reference store keeps only enabled, in-range lanes.
    task automatic blk_write(input int v, input int ofs, input logic [WB-1:0] m,
                             input logic [WB*DW-1:0] d);
        total++;
        if (wr_ready !== 1'b1) begin
            bad++; $display("FAIL wr_ready: got %b want 1", wr_ready);
        end
        wr_valid = 1'b1; wr_var = v[1:0]; wr_offset = ofs[OB-1:0];
        wr_mask = m; wr_data = d;
        tick();
        wr_valid = 1'b0; wr_mask = '0;
        for (int i = 0; i < WB; i++)
            if (m[i] && (ofs*WB + i) < CORES) ref_mem[ofs*WB + i][v] = d[i*DW +: DW];
        $display("write var=%0d ofs=%0d mask=%b", v, ofs, m);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (wr_ready !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL start_collect: got ready=%b busy=%b want 1 1", wr_ready, busy);
        end
    endtask

    task automatic load_all(input logic dup);
        for (int v = 0; v < 4; v++)
            for (int o = 0; o < 4; o++) begin
                blk_write(v, o, 4'hF, rnd_blk());
                if (dup && v == 1 && o == 1) begin
                    blk_write(1, 1, 4'hF, rnd_blk());
                    total++;
                    if (err !== DUP_EN) begin
                        bad++; $display("FAIL dup_err: got %b want %b", err, DUP_EN);
                    end
                end
            end
    endtask

    // Odd cores get od[], even cores get ev[] (lane parity equals core parity).
    task automatic load_vals(input logic [3:0][DW-1:0] ev, input logic [3:0][DW-1:0] od);
        logic [WB*DW-1:0] b;
        for (int v = 0; v < 4; v++)
            for (int o = 0; o < 4; o++) begin
                for (int i = 0; i < WB; i++) b[i*DW +: DW] = (i % 2 == 0) ? ev[v] : od[v];
                blk_write(v, o, 4'hF, b);
            end
    endtask

    // Called one cycle after the final write: nothing yet, core 0 next cycle.
    task automatic check_latency();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || wr_ready !== 1'b0) begin
            bad++; $display("FAIL lat_n1: got valid=%b busy=%b ready=%b want 0 1 0",
                            out_valid, busy, wr_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_core !== '0) begin
            bad++; $display("FAIL lat_n2: got valid=%b core=%0d want 1 0", out_valid, out_core);
        end
    endtask

    // pattern 0: ready high, 1: ready 1,0,0,1 repeating, 2: random ready.
    task automatic drain_check(input int pattern);
        int got = 0;
        int cyc = 0;
        logic st = 1'b0;
        logic [CB-1:0] hc = '0;
        logic [DW-1:0] hs = '0;
        logic [3:0] pat = 4'b1001;
        while (got < CORES && cyc < 500) begin
            case (pattern)
                0: out_ready = 1'b1;
                1: out_ready = pat[cyc % 4];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (st) begin
                total++;
                if (out_valid !== 1'b1 || out_core !== hc || out_sum !== hs) begin
                    bad++; $display("FAIL stall_hold: got v=%b c=%0d s=%h want 1 %0d %h",
                                    out_valid, out_core, out_sum, hc, hs);
                end
            end
            if (pattern == 0 && got > 0) begin
                total++;
                if (out_valid !== 1'b1) begin
                    bad++; $display("FAIL gap: got valid=%b want 1 at core %0d", out_valid, got);
                end
            end
            st = 1'b0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    total++;
                    if (out_core !== CB'(got) || out_sum !== exp_sum(got)) begin
                        bad++; $display("FAIL sum: got core=%0d sum=%h want %0d %h",
                                        out_core, out_sum, got, exp_sum(got));
                    end
                    $display("sum core=%0d val=%h", out_core, out_sum);
                    got++;
                end else begin
                    st = 1'b1; hc = out_core; hs = out_sum;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        total++;
        if (got != CORES) begin
            bad++; $display("FAIL drain_timeout: got %0d sums want %0d", got, CORES);
        end
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL done_pulse: got done=%b valid=%b want 1 0", done, out_valid);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL done_end: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if (wr_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || out_core !== '0 || out_sum !== '0) begin
            bad++; $display("FAIL reset: got rdy=%b v=%b busy=%b done=%b err=%b core=%0d sum=%h want all 0",
                            wr_ready, out_valid, busy, done, err, out_core, out_sum);
        end
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_basic();
        logic [3:0][DW-1:0] v;
        v[0] = 32'd10; v[1] = 32'd4; v[2] = 32'd3; v[3] = 32'd20;
        do_start();
        load_vals(v, v);
        check_latency();
        total++;
        if (out_sum !== 32'd23) begin
            bad++; $display("FAIL basic_const: got %0d want 23", out_sum);
        end
        drain_check(0);
    endtask

    task automatic test_partial_order();
        int ord [4] = '{3, 0, 2, 1};
        do_start();
        for (int k = 0; k < 4; k++) begin
            for (int o = 0; o < 3; o++) blk_write(ord[k], o, 4'hF, rnd_blk());
            blk_write(ord[k], 3, 4'b0011, rnd_blk());
            if (k == 3) begin
                for (int w = 0; w < 3; w++) begin
                    total++;
                    if (out_valid !== 1'b0 || wr_ready !== 1'b1) begin
                        bad++; $display("FAIL partial_wait: got valid=%b ready=%b want 0 1",
                                        out_valid, wr_ready);
                    end
                    tick();
                end
            end
            blk_write(ord[k], 3, 4'b1100, rnd_blk());
        end
        check_latency();
        drain_check(2);
    endtask

    task automatic test_backpressure();
        do_start();
        load_all(1'b0);
        check_latency();
        drain_check(1);
    endtask

    task automatic test_wrap();
        logic [3:0][DW-1:0] ev;
        logic [3:0][DW-1:0] od;
        ev[0] = 32'h0; ev[1] = 32'hFFFF_FFFF; ev[2] = 32'h1; ev[3] = 32'h0;
        od[0] = 32'd5; od[1] = 32'd6;         od[2] = 32'h0; od[3] = 32'h0;
        do_start();
        load_vals(ev, od);
        check_latency();
        total++;
        if (out_sum !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap_even: got %h want 00000000", out_sum);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_core !== 4'd1 || out_sum !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL wrap_odd: got core=%0d sum=%h want 1 ffffffff", out_core, out_sum);
        end
        // Core 0 and core 1 are already consumed/presented; finish by hand.
        for (int c = 1; c < CORES; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_core !== CB'(c) || out_sum !== exp_sum(c)) begin
                bad++; $display("FAIL wrap_sum: got v=%b core=%0d sum=%h want 1 %0d %h",
                                out_valid, out_core, out_sum, c, exp_sum(c));
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL wrap_done: got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_abort();
        do_start();
        load_all(1'b0);
        check_latency();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_core !== CB'(k) || out_sum !== exp_sum(k)) begin
                bad++; $display("FAIL abort_pre: got core=%0d sum=%h want %0d %h",
                                out_core, out_sum, k, exp_sum(k));
            end
            tick();
        end
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || wr_ready !== 1'b1) begin
            bad++; $display("FAIL abort: got valid=%b busy=%b ready=%b want 0 1 1",
                            out_valid, busy, wr_ready);
        end
        $display("abort issued after 5 sums");
        load_all(1'b0);
        check_latency();
        drain_check(0);
    endtask

    task automatic test_dup();
        do_start();
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL dup_pre: got %b want 0", err);
        end
        load_all(1'b1);
        check_latency();
        drain_check(2);
        total++;
        if (err !== DUP_EN) begin
            bad++; $display("FAIL dup_sticky: got %b want %b", err, DUP_EN);
        end
        do_start();
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL dup_clear: got %b want 0", err);
        end
    endtask

    task automatic test_reset_mid();
        blk_write(0, 0, 4'hF, rnd_blk());
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (busy !== 1'b0 || wr_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got busy=%b rdy=%b v=%b err=%b want 0 0 0 0",
                            busy, wr_ready, out_valid, err);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial_order();
        test_backpressure();
        test_wrap();
        test_abort();
        test_dup();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
